// File: rtl/wide_mem_pkg.sv
// rtl/wide_mem_pkg.sv - shared state enum, word width and address slicing helpers for wide_mem_initiator
package wide_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WRITE   = 2'd2,
      RESP    = 2'd3
   } wide_mem_state_e;

   localparam int WordWidth = 32;

   // off_w is the number of byte-offset bits inside one line
   function automatic logic [31:0] word_sel(input logic [31:0] addr, input int off_w);
      return (addr >> 2) & ((32'd1 << (off_w - 2)) - 32'd1);
   endfunction

   function automatic logic [31:0] line_sel(input logic [31:0] addr, input int off_w);
      return addr >> off_w;
   endfunction

endpackage

// File: rtl/wide_mem_merge.sv
// rtl/wide_mem_merge.sv - combinational byte-enable merge of one 32-bit word into a RAM line
module wide_mem_merge
   import wide_mem_pkg::*;
#(
   parameter int LineWidth = 128,
   parameter int WselW     = 2
) (
   input  logic [LineWidth-1:0] line,
   input  logic [WselW-1:0]     word_idx,
   input  logic [WordWidth-1:0] wdata,
   input  logic [3:0]           be,
   output logic [LineWidth-1:0] merged
);

   always_comb begin
      merged = line;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) merged[word_idx*WordWidth + b*8 +: 8] = wdata[b*8 +: 8];
      end
   end

endmodule

// File: rtl/wide_mem_initiator.sv
// rtl/wide_mem_initiator.sv - 32-bit word requester to wide single-port RAM initiator with RMW writes
// Optional one-line read buffer compiled in with WIDE_MEM_LINE_BUF_EN.
module wide_mem_initiator
   import wide_mem_pkg::*;
#(
   parameter int LineWidth = 128,
   parameter int Depth     = 256,
   parameter int AddrW     = $clog2(Depth) + $clog2(LineWidth/8)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [AddrW-1:0]         req_addr_i,
   input  logic [WordWidth-1:0]     req_wdata_i,
   input  logic [3:0]               req_be_i,
   output logic                     resp_valid_o,
   output logic [WordWidth-1:0]     resp_rdata_o,
   output logic                     ram_req_o,
   output logic                     ram_we_o,
   output logic [$clog2(Depth)-1:0] ram_addr_o,
   output logic [LineWidth-1:0]     ram_wdata_o,
   input  logic [LineWidth-1:0]     ram_rdata_i
);

   localparam int OffW  = $clog2(LineWidth/8);
   localparam int LidxW = $clog2(Depth);
   localparam int WselW = OffW - 2;

   wide_mem_state_e state, next_state;

   logic                 we_q;
   logic [WselW-1:0]     widx_q;
   logic [WordWidth-1:0] wdata_q;
   logic [3:0]           be_q;
   logic [LidxW-1:0]     lidx_q;
   logic [LineWidth-1:0] line_q;
   logic [LineWidth-1:0] merged;
   logic [WordWidth-1:0] rdata_q;
   logic [LidxW-1:0]     req_lidx;
   logic [WselW-1:0]     req_widx;
   logic                 accept;
   logic                 hit;
   logic [WordWidth-1:0] hit_word;

   assign req_lidx = LidxW'(line_sel(32'(req_addr_i), OffW));
   assign req_widx = WselW'(word_sel(32'(req_addr_i), OffW));

`ifdef WIDE_MEM_LINE_BUF_EN
   logic                 buf_valid;
   logic [LidxW-1:0]     buf_tag;
   logic [LineWidth-1:0] buf_line;

   assign hit      = req_valid_i && !req_we_i && buf_valid && (buf_tag == req_lidx);
   assign hit_word = buf_line[req_widx*WordWidth +: WordWidth];

   // Buffer mirrors the last line touched in RAM, including the merged write-back
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_line  <= '0;
      end else if (state == RD_WAIT) begin
         buf_valid <= 1'b1;
         buf_tag   <= lidx_q;
         buf_line  <= ram_rdata_i;
      end else if (state == WRITE) begin
         buf_line  <= line_q;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_word = '0;
`endif

   wide_mem_merge #(
      .LineWidth (LineWidth),
      .WselW     (WselW)
   ) u_merge (
      .line     (ram_rdata_i),
      .word_idx (widx_q),
      .wdata    (wdata_q),
      .be       (be_q),
      .merged   (merged)
   );

   // rst_ni gating keeps the RAM request low while reset holds, even with a pending request
   always_comb begin
      next_state  = state;
      req_ready_o = 1'b0;
      accept      = 1'b0;
      ram_req_o   = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      case (state)
         IDLE: begin
            req_ready_o = rst_ni;
            if (req_valid_i) begin
               accept     = rst_ni;
               next_state = hit ? RESP : RD_WAIT;
               ram_req_o  = rst_ni && !hit;
               ram_addr_o = hit ? '0 : req_lidx;
            end
         end
         RD_WAIT: next_state = we_q ? WRITE : RESP;
         WRITE: begin
            ram_req_o  = 1'b1;
            ram_we_o   = 1'b1;
            ram_addr_o = lidx_q;
            next_state = RESP;
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= next_state;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q    <= 1'b0;
         widx_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         lidx_q  <= '0;
         line_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= req_we_i;
            widx_q  <= req_widx;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            lidx_q  <= req_lidx;
            if (hit) rdata_q <= hit_word;
         end
         if (state == RD_WAIT) begin
            rdata_q <= ram_rdata_i[widx_q*WordWidth +: WordWidth];
            if (we_q) line_q <= merged;
         end
      end
   end

   assign resp_valid_o = (state == RESP);
   assign resp_rdata_o = rdata_q;
   assign ram_wdata_o  = line_q;

endmodule

// File: tb/tb_wide_mem_initiator.sv
// tb/tb_wide_mem_initiator.sv - self-checking bench for wide_mem_initiator with RAM and word-level reference model
module tb_wide_mem_initiator;

   localparam int LW = 128;
   localparam int D  = 256;
   localparam int AW = 12;
   localparam int NL = 16;
`ifdef WIDE_MEM_LINE_BUF_EN
   localparam bit BufEn = 1'b1;
`else
   localparam bit BufEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [3:0]    req_be;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          ram_req, ram_we;
   logic [7:0]    ram_addr;
   logic [LW-1:0] ram_wdata, ram_rdata;

   logic [LW-1:0] mem [D];
   logic [31:0]   ref_w [NL*4];
   logic          ld_en;
   logic [7:0]    ld_line;
   logic [LW-1:0] ld_data;
   int            ram_req_cnt = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   bit            buf_valid_m;
   int            buf_tag_m;

   always #5 clk = ~clk;

   wide_mem_initiator dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .req_be_i     (req_be),
      .resp_valid_o (resp_valid),
      .resp_rdata_o (resp_rdata),
      .ram_req_o    (ram_req),
      .ram_we_o     (ram_we),
      .ram_addr_o   (ram_addr),
      .ram_wdata_o  (ram_wdata),
      .ram_rdata_i  (ram_rdata)
   );

   // ram_1pc stand-in, with a preload port used only while the design is in reset
   always @(posedge clk) begin
      if (ld_en) mem[ld_line] <= ld_data;
      else if (ram_req) begin
         ram_req_cnt <= ram_req_cnt + 1;
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] ref_line(input int line);
      logic [LW-1:0] l;
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_w[line*4 + w];
      return l;
   endfunction

   // One request from accept to response; expectations come from the word-level model
   task automatic do_op(input bit we, input logic [AW-1:0] addr, input logic [31:0] wd, input logic [3:0] be);
      int            line, w, exp_lat, lat, guard;
      bit            hit;
      logic [31:0]   exp_rd;
      logic [LW-1:0] exp_line;
      line    = int'(addr) / 16;
      w       = (int'(addr) / 4) % 4;
      hit     = BufEn && !we && buf_valid_m && (buf_tag_m == line);
      exp_lat = hit ? 1 : (we ? 3 : 2);
      exp_rd  = ref_w[line*4 + w];
      if (we)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_w[line*4 + w][b*8 +: 8] = wd[b*8 +: 8];
      exp_line = ref_line(line);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
      #1;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      chk("ready_idle", req_ready, 1);
      chk("ram_req_accept", ram_req, !hit);
      if (!hit) begin
         chk("ram_we_accept", ram_we, 0);
         chk("ram_addr_accept", ram_addr, line);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         chk("ready_busy", req_ready, 0);
         if (we && lat == 2) begin
            chk("wr_req_we", {ram_req, ram_we}, 2'b11);
            chk("wr_addr", ram_addr, line);
            chk("wr_line", ram_wdata, exp_line);
         end
         @(posedge clk); #1; lat++;
      end
      chk("resp_latency", lat, exp_lat);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("ready_resp", req_ready, 0);
      if (!hit) begin
         buf_valid_m = 1'b1;
         buf_tag_m   = line;
      end
   endtask

   initial begin
      logic [LW-1:0] orig;
      logic [31:0]   d;
      int            c0;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0] orig;
      int            c0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      ld_en = 1'b1; ld_line = '0; ld_data = '0;
      buf_valid_m = 1'b0; buf_tag_m = 0;
      for (int l = 0; l < NL; l++) begin
         for (int w = 0; w < 4; w++) begin
            ref_w[l*4 + w] = (l == 1) ? 32'h11111111 : (l == 2) ? 32'h22222222 : $urandom;
            ld_data[w*32 +: 32] = ref_w[l*4 + w];
         end
         ld_line = 8'(l);
         @(posedge clk); #1;
      end
      ld_en = 1'b0;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_ram_req", ram_req, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", req_ready, 1);

      do_op(1'b0, 12'h014, 32'h0, 4'h0);
      chk("read_line1", resp_rdata, 32'h11111111);
      do_op(1'b1, 12'h024, 32'hAABBCCDD, 4'b0011);
      chk("write_preword", resp_rdata, 32'h22222222);
      chk("mem_line2", mem[2], {32'h22222222, 32'h22222222, 32'h2222CCDD, 32'h22222222});
      do_op(1'b0, 12'h024, 32'h0, 4'h0);
      chk("readback_0x024", resp_rdata, 32'h2222CCDD);

      do_op(1'b0, 12'h010, 32'h0, 4'h0);
      chk("b2b_first", resp_rdata, 32'h11111111);
      do_op(1'b0, 12'h020, 32'h0, 4'h0);
      chk("b2b_second", resp_rdata, 32'h22222222);

      orig = mem[3];
      do_op(1'b1, 12'h030, $urandom, 4'b0000);
      chk("be0_line3_unchanged", mem[3], orig);

      do_op(1'b0, 12'h050, 32'h0, 4'h0);
      c0 = ram_req_cnt;
      do_op(1'b0, 12'h010, 32'h0, 4'h0);
      do_op(1'b0, 12'h018, 32'h0, 4'h0);
      chk("buf_read_0x018", resp_rdata, 32'h11111111);
      chk("ram_req_pulses", ram_req_cnt - c0, BufEn ? 1 : 2);

      // Reset lands in the WRITE cycle of a write to line 4
      orig = mem[4];
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h044; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
      #1;
      chk("rst_wr_ready", req_ready, 1);
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_wr_in_write", {ram_req, ram_we}, 2'b11);
      rst_n = 1'b0; #1;
      chk("rst_mid_ram_req", ram_req, 0);
      chk("rst_mid_ram_we", ram_we, 0);
      chk("rst_mid_ram_addr", ram_addr, 0);
      chk("rst_mid_ram_wdata", ram_wdata, 0);
      chk("rst_mid_resp_valid", resp_valid, 0);
      chk("rst_mid_resp_rdata", resp_rdata, 0);
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1'b1; buf_valid_m = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_no_write", mem[4], orig);
      chk("rst_mid_ready", req_ready, 1);
      chk("rst_mid_no_resp", resp_valid, 0);
      do_op(1'b0, 12'h044, 32'h0, 4'h0);

      for (int i = 0; i < 40; i++) begin
         logic [AW-1:0] a;
         a = AW'($urandom_range(0, 7) * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
         do_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
      end
      for (int l = 0; l < 8; l++) chk("final_mem", mem[l], ref_line(l));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
